// File: rtl/fp_seq_multiplier.sv
// -----------------------------------------------------------------------------
// fp_seq_multiplier
//
// Iterative radix-2 Booth signed fixed-point multiplier for the FC-layer
// datapath. It sits between the weight/activation fetch logic and the FC
// accumulator. Each operation takes SIZE Booth steps, one per clock.
//
// Parameters
//   SIZE      operand/result width, two's complement (SIZE >= 4)
//   PRECISION fraction bits of operands and result (1 <= PRECISION < SIZE)
//   SATURATE  1: clamp to max/min on overflow, 0: wrap (keep low SIZE bits)
//
// Build option
//   FP_SEQ_MULT_ROUND_EN  defined   : round half-up before the fraction shift
//                         undefined : truncate toward -inf (arithmetic shift)
//   Latency and handshake are the same in both builds.
//
// Ports
//   clk           in   1     rising-edge clock
//   rst_n         in   1     asynchronous active-low reset
//   in_valid      in   1     operands present
//   in_ready      out  1     block can accept operands (high only in IDLE)
//   multiplicand  in   SIZE  signed operand A
//   multiplier    in   SIZE  signed operand B
//   out_valid     out  1     product/overflow valid (high only in DONE)
//   out_ready     in   1     downstream accepts the result
//   product       out  SIZE  signed fixed-point result
//   overflow      out  1     result not representable in SIZE bits
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_valid is only looked at in IDLE, out_ready only in DONE.
// out_valid, product and overflow stay stable until the transfer. Operands
// are sampled on the accept edge only.
//
// Timing: accept edge -> SIZE BUSY steps -> out_valid rises exactly SIZE
// cycles after the accept edge. With out_ready held high, a new operand pair
// can be accepted every SIZE+2 cycles.
// -----------------------------------------------------------------------------
module fp_seq_multiplier #(
  parameter int SIZE      = 16,
  parameter int PRECISION = 11,
  parameter int SATURATE  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] multiplicand,
  input  logic [SIZE-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] product,
  output logic            overflow
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  // The accumulator upper half is one bit wider than the operands. Without
  // this guard bit, subtracting the most-negative multiplicand would overflow
  // the partial sum. With it, every Booth step is exact.
  localparam int AW = 2 * SIZE + 2;
  localparam int CW = $clog2(SIZE + 1);
  localparam int RW = 2 * SIZE + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_STEP = CW'(SIZE - 1);

`ifdef FP_SEQ_MULT_ROUND_EN
  // Half an output LSB, added before the fraction shift.
  localparam logic [RW-1:0] RND_ADD = {{(RW-1){1'b0}}, 1'b1} << (PRECISION - 1);
`else
  localparam logic [RW-1:0] RND_ADD = '0;
`endif

  localparam logic [SIZE-1:0] MAX_POS = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic [SIZE-1:0] MAX_NEG = {1'b1, {(SIZE-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]      state;      // FSM state, visible for checkers
  logic [SIZE-1:0] mcand;      // latched multiplicand A
  logic [AW-1:0]   acc;        // {upper(SIZE+1), multiplier(SIZE), booth bit}
  logic [CW-1:0]   cnt;        // Booth steps already done

  // ---------------------------------------------------------------------------
  // One Booth step: add or subtract A on the upper half, then shift right
  // arithmetically by one bit.
  // ---------------------------------------------------------------------------
  logic [SIZE:0]   upper;
  logic [SIZE:0]   upper_sum;
  logic [SIZE:0]   mcand_ext;
  logic [AW-1:0]   acc_step;

  always_comb begin
    upper     = acc[AW-1:SIZE+1];
    mcand_ext = {mcand[SIZE-1], mcand};
    upper_sum = upper;
    case (acc[1:0])
      2'b01:   upper_sum = upper + mcand_ext;
      2'b10:   upper_sum = upper - mcand_ext;
      default: upper_sum = upper;
    endcase
    acc_step = {upper_sum[SIZE], upper_sum, acc[SIZE:1]};
  end

  // ---------------------------------------------------------------------------
  // Result formatting, evaluated on the accumulator value after the final
  // step. After SIZE steps the full 2*SIZE-bit product sits in acc[2*SIZE:1].
  // ---------------------------------------------------------------------------
  logic [2*SIZE-1:0]        p_full;
  logic signed [RW-1:0]     p_ext;
  logic signed [RW-1:0]     r_ext;
  logic [SIZE+1:0]          r_high;
  logic                     ovf_next;
  logic [SIZE-1:0]          prod_next;

  always_comb begin
    p_full = acc_step[2*SIZE:1];
    // The rounding add is done one bit wider than the product, so it cannot
    // wrap even for the largest positive product.
    p_ext  = {p_full[2*SIZE-1], p_full} + RND_ADD;
    r_ext  = p_ext >>> PRECISION;
    // The value fits in SIZE bits only when everything from the result sign
    // bit upward is a plain sign extension.
    r_high   = r_ext[RW-1:SIZE-1];
    ovf_next = !((&r_high) || (~|r_high));
    if ((SATURATE != 0) && ovf_next) begin
      // The clamp direction comes from the sign of the exact product.
      prod_next = p_full[2*SIZE-1] ? MAX_NEG : MAX_POS;
    end else begin
      prod_next = r_ext[SIZE-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: IDLE -> BUSY -> DONE -> IDLE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand <= multiplicand;
            acc   <= {{(SIZE+1){1'b0}}, multiplier, 1'b0};
            cnt   <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            product  <= prod_next;
            overflow <= ovf_next;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_fp_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_fp_seq_multiplier
//
// Self-checking bench for fp_seq_multiplier (SIZE=16, PRECISION=11,
// SATURATE=1). Expected results come from a longint arithmetic model of the
// product, the fraction shift, the range check and the clamp rules. The model
// follows FP_SEQ_MULT_ROUND_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fp_seq_multiplier;

  localparam int SIZE = 16;
  localparam int PREC = 11;
  localparam int SAT  = 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [SIZE-1:0] multiplicand = '0;
  logic [SIZE-1:0] multiplier = '0;
  logic            in_ready;
  logic            out_valid;
  logic [SIZE-1:0] product;
  logic            overflow;

  always #5 clk = ~clk;

  fp_seq_multiplier #(.SIZE(SIZE), .PRECISION(PREC), .SATURATE(SAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .overflow     (overflow)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [SIZE:0] exp_q[$];   // {overflow, product}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: exact signed product, then scale down by 2^PREC.
  function automatic void model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                output logic [SIZE-1:0] p, output logic o);
    longint pa;
    longint r;
    pa = longint'($signed(a)) * longint'($signed(b));
`ifdef FP_SEQ_MULT_ROUND_EN
    r = (pa + (longint'(1) <<< (PREC - 1))) >>> PREC;
`else
    r = pa >>> PREC;
`endif
    o = (r > 32767) || (r < -32768);
    if (o && (SAT != 0)) p = (pa < 0) ? 16'h8000 : 16'h7FFF;
    else                 p = r[SIZE-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one full operation with latency, result, backpressure and release
  // checks. 'hold' is the number of DONE cycles with out_ready low.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input int hold);
    logic [SIZE-1:0] ep;
    logic            eo;
    logic [SIZE:0]   e;
    logic [SIZE-1:0] held;
    int              lat;
    bit              got;

    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    if (!got) begin
      check("idle_timeout", 32'd0, 32'd1);
      return;
    end

    in_valid = 1'b1; multiplicand = a; multiplier = b;
    model(a, b, ep, eo);
    exp_q.push_back({eo, ep});
    @(posedge clk); #1;
    // Operands change right after the accept edge and must have no effect.
    in_valid = 1'b0; multiplicand = SIZE'($urandom); multiplier = SIZE'($urandom);
    check("busy_in_ready", 32'(in_ready), 32'd0);

    lat = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else begin
        // in_valid and out_ready toggle randomly while BUSY and must be ignored.
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        multiplicand = SIZE'($urandom);
        @(posedge clk); #1;
        lat++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end

    check("latency", 32'(lat), 32'(SIZE));
    e = exp_q.pop_front();
    check("product", 32'(product), 32'(e[SIZE-1:0]));
    check("overflow", 32'(overflow), 32'(e[SIZE]));
    check("done_in_ready", 32'(in_ready), 32'd0);
    held = product;

    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; multiplicand = SIZE'($urandom); multiplier = SIZE'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_product", 32'(product), 32'(held));
    end

    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : main
    logic [SIZE-1:0] ra;
    logic [SIZE-1:0] rb;
    logic [SIZE-1:0] corner [4];
    int t0;
    int t1;
    int cyc;
    bit got;

    corner[0] = 16'h8000; corner[1] = 16'h7FFF;
    corner[2] = 16'h0000; corner[3] = 16'hFFFF;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed operations
    run_op(16'h0C00, 16'h1000, 0);
    check("lit_1p5x2", 32'(product), 32'h1800);
    run_op(16'hF400, 16'h1000, 1);
    run_op(16'h0800, 16'hF800, 0);
    run_op(16'h4000, 16'h4000, 5);
    run_op(16'h8000, 16'h8000, 2);
    check("lit_minneg_sq", 32'(product), 32'h7FFF);
    run_op(16'h0001, 16'h0400, 0);
    run_op(16'hFFFF, 16'h0400, 0);
    run_op(16'h8000, 16'h7FFF, 0);
    run_op(16'h7FFF, 16'h8000, 0);
    run_op(16'h7FFF, 16'h7FFF, 0);
    run_op(16'h0000, 16'h8000, 0);
    run_op(16'hC000, 16'h4000, 0);
    run_op(16'h0555, 16'hFAAA, 0);

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    in_valid = 1'b1; multiplicand = 16'h0C00; multiplier = 16'h1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_output", 32'(out_valid), 32'd0);
    run_op(16'hF400, 16'h1000, 0);

    // Throughput with in_valid and out_ready held high
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; multiplicand = 16'h0C00; multiplier = 16'h1000;
    t0 = -1; t1 = -1; cyc = 0;
    for (int i = 0; i < 80 && t1 < 0; i++) begin
      if (i != 0) @(negedge clk);
      cyc++;
      if (in_ready) begin
        if (t0 < 0) t0 = cyc;
        else        t1 = cyc;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (t1 < 0) check("throughput_timeout", 32'd0, 32'd1);
    else        check("throughput", 32'(t1 - t0), 32'(SIZE + 2));
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    out_ready = 1'b0;
    if (!got) check("drain_timeout", 32'd0, 32'd1);

    // Randomised operations, biased towards corner operands
    for (int n = 0; n < 30; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : SIZE'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : SIZE'($urandom);
      run_op(ra, rb, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
